// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
//
// Control sequencer for the fetch + conditional-branch path of the RISC
// datapath. Walks T0..T6 issuing the datapath strobes, stretches the memory
// read in T1 by MEM_WAIT cycles, flags non-branch opcodes at T3 and keeps
// saturating counts of executed and taken branches.
//
// Ports:
//   clock, clear          rising-edge clock, synchronous active-high reset
//   start                 request one fetch+branch sequence (sampled in IDLE/T6)
//   ir_op                 IR[31:27] from the datapath
//   con_out               CON flip-flop output, used only in T6
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse on the final cycle of a sequence
//   illegal_op            sticky flag: last sequence saw a non-branch opcode
//   pc_out .. c_out       datapath strobes
//   alu_code              ALU operation select
//   branch_count          completed branch sequences (saturating)
//   taken_count           branches taken in T6 (saturating)
// ---------------------------------------------------------------------------
module branch_sequencer #(
    parameter int         MEM_WAIT = 0,
    parameter logic [4:0] OPC_BR   = 5'b10010,
    parameter logic [4:0] ALU_INC  = 5'b11111,
    parameter logic [4:0] ALU_ADD  = 5'b00011,
    parameter int         CNT_W    = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       ir_op,
    input  logic             con_out,
    output logic             busy,
    output logic             done,
    output logic             illegal_op,
    output logic             pc_out,
    output logic             mar_in,
    output logic             z_in,
    output logic             zlo_out,
    output logic             pc_in,
    output logic             mem_read,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             gra,
    output logic             r_out,
    output logic             con_in,
    output logic             y_in,
    output logic             c_out,
    output logic [4:0]       alu_code,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [3:0] MW = 4'(MEM_WAIT);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            illegal_q    <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            illegal_q    <= illegal_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        illegal_d    = illegal_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        done         = 1'b0;
        pc_out       = 1'b0;
        mar_in       = 1'b0;
        z_in         = 1'b0;
        zlo_out      = 1'b0;
        pc_in        = 1'b0;
        mem_read     = 1'b0;
        mdr_in       = 1'b0;
        mdr_out      = 1'b0;
        ir_in        = 1'b0;
        gra          = 1'b0;
        r_out        = 1'b0;
        con_in       = 1'b0;
        y_in         = 1'b0;
        c_out        = 1'b0;
        alu_code     = 5'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_T0;
                    illegal_d = 1'b0;  // new sequence clears the sticky flag
                end
            end
            S_T0: begin
                pc_out   = 1'b1;
                mar_in   = 1'b1;
                z_in     = 1'b1;
                alu_code = ALU_INC;
                wcnt_d   = '0;
                state_d  = S_T1;
            end
            S_T1: begin
                // memread is held for MEM_WAIT extra cycles; MDR captures
                // only on the last one, together with the PC+1 writeback.
                mem_read = 1'b1;
                if (wcnt_q < MW) begin
                    wcnt_d = wcnt_q + 4'd1;
                end else begin
                    zlo_out = 1'b1;
                    pc_in   = 1'b1;
                    mdr_in  = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (ir_op == OPC_BR) begin
                    gra     = 1'b1;
                    r_out   = 1'b1;
                    con_in  = 1'b1;
                    state_d = S_T4;
                end else begin
                    // Not a branch: end early, counters left untouched.
                    done      = 1'b1;
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_T4: begin
                pc_out  = 1'b1;
                y_in    = 1'b1;
                state_d = S_T5;
            end
            S_T5: begin
                c_out    = 1'b1;
                z_in     = 1'b1;
                alu_code = ALU_ADD;
                state_d  = S_T6;
            end
            S_T6: begin
                done = 1'b1;
                if (con_out) begin
                    zlo_out = 1'b1;
                    pc_in   = 1'b1;
                end
                if (branch_cnt_q != '1)
                    branch_cnt_d = branch_cnt_q + CNT_W'(1);
                if (con_out && (taken_cnt_q != '1))
                    taken_cnt_d = taken_cnt_q + CNT_W'(1);
                if (start) begin
                    state_d   = S_T0;  // back-to-back, no idle cycle
                    illegal_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign illegal_op   = illegal_q;
    assign branch_count = branch_cnt_q;
    assign taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

    localparam int PC_OUT = 13, MAR_IN = 12, Z_IN = 11, ZLO_OUT = 10, PC_IN = 9,
                   MEM_READ = 8, MDR_IN = 7, MDR_OUT = 6, IR_IN = 5, GRA = 4,
                   R_OUT = 3, CON_IN = 2, Y_IN = 1, C_OUT = 0;
    localparam logic [4:0] OPC_BR = 5'b10010;
    localparam logic [31:0] BRMI_WORD = {5'b10010, 4'd1, 4'd3, 19'd35};
    localparam logic [31:0] ADD_WORD  = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};

    logic clk, clear;
    int checks, failures;

    // main DUT (MEM_WAIT=0) driven by a small datapath model
    logic start_m, busy_m, done_m, ill_m;
    logic [4:0] ir_op_m, alu_m;
    logic con_m;
    logic [13:0] stb_m;
    logic [15:0] bcnt_m, tcnt_m;

    // MEM_WAIT=3 and CNT_W=2 DUTs with directly driven ir_op/con_out
    logic [4:0] ir_x;
    logic con_x;
    logic start_w, busy_w, done_w, ill_w;
    logic [4:0] alu_w;
    logic [13:0] stb_w;
    logic [15:0] bcnt_w, tcnt_w;
    logic start_c, busy_c, done_c, ill_c;
    logic [4:0] alu_c;
    logic [13:0] stb_c;
    logic [1:0] bcnt_c, tcnt_c;

    branch_sequencer #(.MEM_WAIT(0)) u_dut (
        .clock(clk), .clear(clear), .start(start_m), .ir_op(ir_op_m), .con_out(con_m),
        .busy(busy_m), .done(done_m), .illegal_op(ill_m),
        .pc_out(stb_m[PC_OUT]), .mar_in(stb_m[MAR_IN]), .z_in(stb_m[Z_IN]),
        .zlo_out(stb_m[ZLO_OUT]), .pc_in(stb_m[PC_IN]), .mem_read(stb_m[MEM_READ]),
        .mdr_in(stb_m[MDR_IN]), .mdr_out(stb_m[MDR_OUT]), .ir_in(stb_m[IR_IN]),
        .gra(stb_m[GRA]), .r_out(stb_m[R_OUT]), .con_in(stb_m[CON_IN]),
        .y_in(stb_m[Y_IN]), .c_out(stb_m[C_OUT]), .alu_code(alu_m),
        .branch_count(bcnt_m), .taken_count(tcnt_m));

    branch_sequencer #(.MEM_WAIT(3)) u_dut_w3 (
        .clock(clk), .clear(clear), .start(start_w), .ir_op(ir_x), .con_out(con_x),
        .busy(busy_w), .done(done_w), .illegal_op(ill_w),
        .pc_out(stb_w[PC_OUT]), .mar_in(stb_w[MAR_IN]), .z_in(stb_w[Z_IN]),
        .zlo_out(stb_w[ZLO_OUT]), .pc_in(stb_w[PC_IN]), .mem_read(stb_w[MEM_READ]),
        .mdr_in(stb_w[MDR_IN]), .mdr_out(stb_w[MDR_OUT]), .ir_in(stb_w[IR_IN]),
        .gra(stb_w[GRA]), .r_out(stb_w[R_OUT]), .con_in(stb_w[CON_IN]),
        .y_in(stb_w[Y_IN]), .c_out(stb_w[C_OUT]), .alu_code(alu_w),
        .branch_count(bcnt_w), .taken_count(tcnt_w));

    branch_sequencer #(.CNT_W(2)) u_dut_c2 (
        .clock(clk), .clear(clear), .start(start_c), .ir_op(ir_x), .con_out(con_x),
        .busy(busy_c), .done(done_c), .illegal_op(ill_c),
        .pc_out(stb_c[PC_OUT]), .mar_in(stb_c[MAR_IN]), .z_in(stb_c[Z_IN]),
        .zlo_out(stb_c[ZLO_OUT]), .pc_in(stb_c[PC_IN]), .mem_read(stb_c[MEM_READ]),
        .mdr_in(stb_c[MDR_IN]), .mdr_out(stb_c[MDR_OUT]), .ir_in(stb_c[IR_IN]),
        .gra(stb_c[GRA]), .r_out(stb_c[R_OUT]), .con_in(stb_c[CON_IN]),
        .y_in(stb_c[Y_IN]), .c_out(stb_c[C_OUT]), .alu_code(alu_c),
        .branch_count(bcnt_c), .taken_count(tcnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- minimal datapath: PC, MAR, Y, Z, MDR, IR, R1, CON ----
    logic [31:0] pc, mar, y, z, mdr, ir, r1, bus, alu, cval, mem_word, pc_init, r1_init;
    logic mdl_load, con_ff;

    assign ir_op_m = ir[31:27];
    assign con_m   = con_ff;
    assign cval    = {{13{ir[18]}}, ir[18:0]};

    always_comb begin
        bus = 32'd0;
        if (stb_m[PC_OUT])       bus = pc;
        else if (stb_m[ZLO_OUT]) bus = z;
        else if (stb_m[MDR_OUT]) bus = mdr;
        else if (stb_m[R_OUT])   bus = r1;
        else if (stb_m[C_OUT])   bus = cval;
        alu = 32'd0;
        if (alu_m == 5'b11111)      alu = bus + 32'd1;
        else if (alu_m == 5'b00011) alu = y + bus;
    end

    always @(posedge clk) begin
        if (mdl_load) begin
            pc <= pc_init;
            r1 <= r1_init;
        end else begin
            if (stb_m[PC_IN])  pc <= bus;
            if (stb_m[MAR_IN]) mar <= bus;
            if (stb_m[Z_IN])   z <= alu;
            if (stb_m[Y_IN])   y <= bus;
            if (stb_m[MDR_IN]) mdr <= mem_word;
            if (stb_m[IR_IN])  ir <= bus;
            if (stb_m[CON_IN]) con_ff <= r1[31];  // brmi: R1 negative
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_set(input logic [31:0] pcv, input logic [31:0] r1v);
        pc_init = pcv; r1_init = r1v; mdl_load = 1'b1;
        @(negedge clk);
        mdl_load = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Pulse start on the main DUT; returns latency to done and per-cycle observations.
    task automatic run_main(output int lat, output logic [13:0] seen, output logic [13:0] dstb,
                            output logic busy1, output logic ill1,
                            output logic [4:0] alu1, output logic [4:0] alu6);
        lat = 0; seen = '0; dstb = '0; busy1 = 0; ill1 = 0; alu1 = 0; alu6 = 0;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            seen |= stb_m;
            if (n == 1) begin busy1 = busy_m; ill1 = ill_m; alu1 = alu_m; end
            if (n == 6) alu6 = alu_m;
            if (done_m) begin lat = n; dstb = stb_m; break; end
            @(negedge clk);
        end
    endtask

    int lat, rd_cnt, rd_first, rd_last, mdr_cnt, mdr_at, d1, d2, ndone;
    logic [13:0] seen, dstb;
    logic busy1, ill1, busy_all;
    logic [4:0] alu1, alu6;
    logic [15:0] b0, t0;

    initial begin
        checks = 0; failures = 0;
        clear = 1'b1; start_m = 0; start_w = 0; start_c = 0;
        ir_x = OPC_BR; con_x = 0; mdl_load = 0; mem_word = BRMI_WORD;
        pc_init = 0; r1_init = 0;
        @(negedge clk); @(negedge clk);
        clear = 1'b0;

        // reset state
        chk("rst_main", {busy_m, done_m, ill_m, stb_m, alu_m}, 32'd0);
        chk("rst_cnt_main", {bcnt_m, tcnt_m}, 32'd0);
        chk("rst_w3", {busy_w, done_w, ill_w, stb_w, alu_w}, 32'd0);
        chk("rst_c2", {busy_c, done_c, ill_c, stb_c, alu_c, bcnt_c, tcnt_c}, 32'd0);

        // taken brmi: R1 negative, PC 344 + 1 + 35
        mdl_set(32'd344, 32'h8000000F);
        run_main(lat, seen, dstb, busy1, ill1, alu1, alu6);
        chk("taken_lat", lat, 7);
        chk("taken_busy1", busy1, 1);
        chk("taken_alu_t0", alu1, 5'b11111);
        chk("taken_alu_t5", alu6, 5'b00011);
        chk("taken_t6_zpc", {dstb[ZLO_OUT], dstb[PC_IN]}, 2'b11);
        @(negedge clk);
        chk("taken_pc", pc, 32'd380);
        chk("taken_cnts", {bcnt_m, tcnt_m}, {16'd1, 16'd1});
        chk("taken_idle", busy_m, 0);

        // not taken: R1 positive
        do_clear();
        mdl_set(32'd344, 32'h0000000F);
        run_main(lat, seen, dstb, busy1, ill1, alu1, alu6);
        chk("ntk_lat", lat, 7);
        chk("ntk_t6_zpc", {dstb[ZLO_OUT], dstb[PC_IN]}, 2'b00);
        @(negedge clk);
        chk("ntk_pc", pc, 32'd345);
        chk("ntk_cnts", {bcnt_m, tcnt_m}, {16'd1, 16'd0});

        // MEM_WAIT=3: memread held 4 cycles, MDR capture on the 4th
        ir_x = OPC_BR; con_x = 0;
        rd_cnt = 0; rd_first = 0; rd_last = 0; mdr_cnt = 0; mdr_at = 0; lat = 0;
        start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (stb_w[MEM_READ]) begin
                rd_cnt++;
                if (rd_first == 0) rd_first = n;
                rd_last = n;
            end
            if (stb_w[MDR_IN]) begin mdr_cnt++; mdr_at = rd_cnt; end
            if (done_w) begin lat = n; break; end
            @(negedge clk);
        end
        chk("w3_rd_cnt", rd_cnt, 4);
        chk("w3_rd_span", rd_last - rd_first + 1, 4);
        chk("w3_mdr_once", mdr_cnt, 1);
        chk("w3_mdr_4th", mdr_at, 4);
        chk("w3_lat", lat, 10);
        @(negedge clk);

        // illegal opcode on main DUT
        b0 = bcnt_m; t0 = tcnt_m;
        mem_word = ADD_WORD;
        mdl_set(32'd344, 32'h8000000F);
        run_main(lat, seen, dstb, busy1, ill1, alu1, alu6);
        chk("ill_lat", lat, 4);
        chk("ill_no_br_stb", {seen[GRA], seen[R_OUT], seen[CON_IN]}, 3'b000);
        @(negedge clk);
        chk("ill_flag", ill_m, 1);
        chk("ill_idle", busy_m, 0);
        chk("ill_cnts", {bcnt_m, tcnt_m}, {b0, t0});
        @(negedge clk);
        chk("ill_sticky", ill_m, 1);
        mem_word = BRMI_WORD;
        mdl_set(32'd344, 32'h8000000F);
        run_main(lat, seen, dstb, busy1, ill1, alu1, alu6);
        chk("ill_clr_t0", ill1, 0);
        chk("ill_next_lat", lat, 7);
        @(negedge clk);

        // back-to-back with start held, then clear in T4 of the 3rd
        mdl_set(32'd344, 32'h8000000F);
        d1 = 0; d2 = 0; ndone = 0; busy_all = 1'b1;
        start_m = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 19; n++) begin
            busy_all &= busy_m;
            if (done_m) begin
                ndone++;
                if (ndone == 1) d1 = n;
                if (ndone == 2) d2 = n;
            end
            if (n < 19) @(negedge clk);
        end
        chk("b2b_busy", busy_all, 1);
        chk("b2b_ndone", ndone, 2);
        chk("b2b_d1", d1, 7);
        chk("b2b_gap", d2 - d1, 7);
        chk("b2b_t4_stb", stb_m, 14'd1 << PC_OUT | 14'd1 << Y_IN);
        clear = 1'b1; start_m = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_out", {busy_m, done_m, ill_m, stb_m, alu_m}, 32'd0);
        chk("abort_cnt", {bcnt_m, tcnt_m}, 32'd0);

        // CNT_W=2 saturation with 5 taken branches
        ir_x = OPC_BR; con_x = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            lat = 0;
            start_c = 1'b1;
            @(negedge clk);
            start_c = 1'b0;
            for (int n = 1; n <= 30; n++) begin
                if (done_c) begin lat = n; break; end
                @(negedge clk);
            end
            @(negedge clk);
            if (r == 1) chk("c2_lat", lat, 7);
            if (r == 3) chk("c2_r3", {bcnt_c, tcnt_c}, 4'b1111);
            if (r == 4) chk("c2_r4", {bcnt_c, tcnt_c}, 4'b1111);
        end
        chk("c2_sat", {bcnt_c, tcnt_c}, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
